birthday_sequencer: RTL

Sequencing controller for the six-digit `birthday` seven-segment display. It holds two 6-digit BCD values in slots 1 and 2, drives them onto the display's `a1`/`a2` buses, and toggles the display select `b` at a fixed phase period so that the two values alternate. New values arrive through a valid/ready load port. They are double-buffered and take effect only at a phase boundary, so the display never shows a half-updated value.

---
 rtl/birthday_seq_pkg.sv | 23 ++
 rtl/phase_timer.sv | 40 ++++
 rtl/birthday_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/birthday_seq_pkg.sv
// rtl/birthday_seq_pkg.sv - shared types, constants and BCD helper for the birthday display sequencer
package birthday_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN_1,
    ST_RUN_2,
    ST_PAUSE
  } state_e;

  localparam int         DIGITS  = 6;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic bcd_valid(input logic [DIGITS*4-1:0] value);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (value[i*4 +: 4] > BCD_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - free-running phase counter with hold/clear and terminal-count flag
module phase_timer #(
  parameter int TICKS = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic wrap
);

  localparam int         W    = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         at_last;

  assign at_last = (count_q == LAST);
  // wrap only counts as a boundary when the counter is actually advancing
  assign wrap    = run && !clear && at_last;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = at_last ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/birthday_sequencer.sv
// rtl/birthday_sequencer.sv - alternates two double-buffered BCD slots onto the birthday display
module birthday_sequencer
  import birthday_seq_pkg::*;
#(
  parameter int TICKS_PER_PHASE = 50_000_000,
  parameter bit BCD_CHECK       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        pause,
  input  logic        load_valid,
  input  logic        load_sel,
  input  logic [23:0] load_data,
  output logic        load_ready,
  output logic        load_err,
  output logic [23:0] a1,
  output logic [23:0] a2,
  output logic        b,
  output logic        phase_tick
);

  state_e      state_q;
  logic        b_q;
  logic [23:0] a1_q;
  logic [23:0] a2_q;
  logic        pending_q;
  logic        pending_d;
  logic        shadow_sel_q;
  logic [23:0] shadow_data_q;
  logic        ready_q;
  logic        err_q;
  logic        tick_q;

  logic timer_run;
  logic timer_clear;
  logic boundary;
  logic in_idle;
  logic leaving;
  logic handshake;
  logic data_ok;
  logic accept;
  logic reject;
  logic commit;

  assign in_idle     = (state_q == ST_IDLE);
  assign timer_run   = en && ((state_q == ST_RUN_1) || (state_q == ST_RUN_2));
  assign timer_clear = !en || in_idle;

  phase_timer #(
    .TICKS(TICKS_PER_PHASE)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (timer_run),
    .clear(timer_clear),
    .wrap (boundary)
  );

  assign handshake = load_valid && ready_q;
  assign data_ok   = !BCD_CHECK || bcd_valid(load_data);
  assign accept    = handshake && data_ok;
  assign reject    = handshake && !data_ok;
  assign leaving   = !en && !in_idle;
  // A shadow still pending in IDLE (load accepted as en fell) is flushed immediately
  assign commit    = pending_q && (boundary || leaving || in_idle);

  always_comb begin
    pending_d = pending_q;
    if (commit) pending_d = 1'b0;
    if (accept && !in_idle) pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      b_q           <= 1'b0;
      a1_q          <= '0;
      a2_q          <= '0;
      pending_q     <= 1'b0;
      shadow_sel_q  <= 1'b0;
      shadow_data_q <= '0;
      ready_q       <= 1'b1;
      err_q         <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      err_q     <= reject;
      tick_q    <= boundary;
      pending_q <= pending_d;
      ready_q   <= !pending_d;

      if (accept && !in_idle) begin
        shadow_sel_q  <= load_sel;
        shadow_data_q <= load_data;
      end

      if (commit) begin
        if (shadow_sel_q) a2_q <= shadow_data_q;
        else              a1_q <= shadow_data_q;
      end else if (accept && in_idle) begin
        if (load_sel) a2_q <= load_data;
        else          a1_q <= load_data;
      end

      if (!en) begin
        state_q <= ST_IDLE;
        b_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_RUN_1;
          ST_RUN_1, ST_RUN_2: begin
            if (boundary) begin
              b_q <= !b_q;
              if (pause)                    state_q <= ST_PAUSE;
              else if (state_q == ST_RUN_1) state_q <= ST_RUN_2;
              else                          state_q <= ST_RUN_1;
            end else if (pause) begin
              state_q <= ST_PAUSE;
            end
          end
          // b is frozen while paused, so it records which run state to resume
          ST_PAUSE: begin
            if (!pause) state_q <= b_q ? ST_RUN_2 : ST_RUN_1;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign load_ready = ready_q;
  assign load_err   = err_q;
  assign a1         = a1_q;
  assign a2         = a2_q;
  assign b          = b_q;
  assign phase_tick = tick_q;

endmodule
